press_source: RTL
=================

# press_source

Press-pulse generator driving the `L`/`R` inputs of the tug-of-war playfield lights. Each instance produces one clean, single-cycle `press` per player action. Actions come from one of two sources:
- **Human**: a raw, asynchronous key, synchronized and edge-detected.
- **Computer**: an LFSR-based opponent whose press rate is set by `difficulty`.

A post-press gap enforces a minimum spacing between pulses. One instance is built per player side.

## Interface
Parameters:
- `LFSR_W`, 10: LFSR and `difficulty` width; feedback taps are fixed for 10 bits.
- `MIN_GAP`, 4: cycles in GAP after each press; legal range 1 to 15.
- `SYNC_STAGES`, 2: flops in the key synchronizer; legal values are 2 or 3.

Ports:
- `clk`, in, 1: single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `key_raw`, in, 1: asynchronous key, 1 = pressed.
- `cpu_mode`, in, 1: 1 selects the computer source; 0 selects the human key. Must be quasi-static.
- `difficulty`, in, `LFSR_W`: computer press threshold; larger values press more often.
- `enable`, in, 1: game active. 0 suppresses all presses.
- `press`, out, 1: registered, one-cycle press pulse; connects to the playfield `L` or `R`.
- `lfsr_q`, out, `LFSR_W`: current LFSR state, exposed for debug and test.

## Operation
- **Key synchronizer**
  - `key_raw` passes through `SYNC_STAGES` flops, all reset to 0; the last stage is `key_s`.
  - A `key_d` flop tracks `key_s` every cycle, in both modes.
  - `human_req = ~cpu_mode & key_s & ~key_d`.
  - Because edge tracking runs in both modes, switching modes never fabricates an edge.
- **LFSR**
  - Fibonacci form: `fb = q[9] ^ q[6]` (x^10 + x^7 + 1); update is `q <= {q[8:0], fb}`.
  - Reset seed is 10'h001. The LFSR advances every cycle regardless of `enable` or `cpu_mode`.
  - Maximal period is 1023; the all-zero state is unreachable.
- **Computer request**: `cpu_req = cpu_mode & (lfsr_q < difficulty)`, an unsigned compare.
  - `difficulty = 0` never requests.
- **Request selection**: `req = human_req | cpu_req`; only one term can be nonzero at a time.
- **FSM** (states IDLE, FIRE, GAP; `gap_cnt` is 4 bits):
  - IDLE: if `enable & req`, go to FIRE; otherwise stay in IDLE.
  - FIRE: go to GAP and load `gap_cnt = MIN_GAP`.
  - GAP: decrement `gap_cnt` each cycle; go to IDLE when `gap_cnt` reaches 1 and would decrement to 0.
  - Requests arriving in FIRE or GAP are dropped, not queued.
  - `enable = 0`: next state is IDLE from any state, and `gap_cnt` clears to 0.
- **Output**: `press` is a registered flop, set exactly in the cycles where state = FIRE, and never asserted for two consecutive cycles.
- **Reset values**: `press = 0`, state = IDLE, `gap_cnt = 0`, synchronizer and `key_d` = 0, `lfsr_q` = 10'h001.
  - Reset mid-pulse drops `press` immediately, asynchronously.

## Timing
- **Human latency**: `key_raw` first sampled high at edge k gives `key_s` = 1 after edge k+`SYNC_STAGES`-1.
  - FIRE is entered at edge k+`SYNC_STAGES`, so `press` is high for the one cycle after that edge.
- **Computer latency**: `cpu_req` true in the cycle after edge j means `press` is high for the cycle after edge j+1.
- **Spacing**: minimum press-to-press rising-edge distance is `MIN_GAP`+2 cycles (FIRE, `MIN_GAP` GAP cycles, one IDLE cycle).
- **Held key**: exactly one press per `key_raw` rising edge, regardless of hold length.
  - An edge arriving during GAP is lost; re-pressing is required.
- **Enable drop**:
  - During FIRE, the current pulse completes and the next state is IDLE.
  - During GAP, the next state is IDLE.
  - Re-enable with a request already pending fires one cycle later.

## Test plan
- **LFSR sequence**: reset, then free-run. `lfsr_q` must be 001, 002, 004, 008, 010, 020, 040, 081, 102, 204, 009.
  - It returns to 001 exactly 1023 cycles after reset.
- **Human single press**: `cpu_mode=0`, `enable=1`, `key_raw` 0→1 held 20 cycles.
  - Exactly one `press` pulse, 1 cycle wide, high the cycle after the 2nd edge from first sample (`SYNC_STAGES`=2). No further pulses.
- **Human gap drop**: `MIN_GAP=4`; `key_raw` tapped with 1-cycle pulses whose synchronized edges fall 3 cycles apart.
  - Second tap produces no press.
  - A third tap 8 cycles after the first produces a press.
- **Computer rate extremes**:
  - `difficulty=0`, 2046 cycles: zero presses.
  - `difficulty=10'h3FF`, `MIN_GAP=4`: presses spaced exactly 6 cycles apart, except when IDLE samples `lfsr_q`=10'h3FF.
- **Enable control**:
  - `cpu_mode=1`, `difficulty=10'h3FF`, `enable=0`: no presses.
  - `enable` deasserted mid-GAP: state is IDLE next cycle.
  - `enable` re-asserted: press 1 cycle later.
- **Mode switch and reset**:
  - Key held through a `cpu_mode` 1→0 switch with `difficulty=0`: no press.
  - `reset_n` pulsed low while `press`=1: `press` falls before the next clock edge; all reset values are restored.

Source files
------------

// File: rtl/press_source.sv
// Press-pulse generator for one tug-of-war player. It emits a single-cycle press
// for each human key edge or computer request, then holds off for MIN_GAP cycles.
module press_source #(
  parameter int LFSR_W      = 10,
  parameter int MIN_GAP     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              key_raw,
  input  logic              cpu_mode,
  input  logic [LFSR_W-1:0] difficulty,
  input  logic              enable,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  typedef enum logic [1:0] {IDLE, FIRE, GAP} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   key_d_q;
  logic                   key_s;
  logic                   human_req, cpu_req, req;
  logic                   fb;
  state_t                 state_q, state_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;

  // Edge tracking runs in both modes so that a mode switch cannot create an edge.
  assign key_s     = sync_q[SYNC_STAGES-1];
  assign human_req = ~cpu_mode & key_s & ~key_d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      key_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], key_raw};
      key_d_q <= key_s;
    end
  end

  // x^10 + x^7 + 1, free-running; the seed keeps it off the all-zero lockup state.
  assign fb = lfsr_q[9] ^ lfsr_q[6];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= LFSR_W'(1);
    else          lfsr_q <= {lfsr_q[LFSR_W-2:0], fb};
  end

  assign cpu_req = cpu_mode & (lfsr_q < difficulty);
  assign req     = human_req | cpu_req;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: if (req) state_d = FIRE;
      FIRE: begin
        state_d   = GAP;
        gap_cnt_d = 4'(MIN_GAP);
      end
      GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling the game abandons any gap; requests seen while busy are never queued.
    if (!enable) begin
      state_d   = IDLE;
      gap_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      gap_cnt_q <= '0;
      press     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      press     <= (state_d == FIRE);
    end
  end

endmodule
